// File: rtl/retire_trace_buf.sv
// Retire trace buffer: turns the processor's per-cycle retire signals into
// classified trace records, queues them in a small first-word-fall-through
// FIFO for a downstream consumer, and keeps instruction/cycle/drop counters.
module retire_trace_buf #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        halt,
    input  logic        rec_ready,
    output logic        rec_valid,
    output logic [2:0]  rec_kind,
    output logic [31:0] rec_inum,
    output logic [15:0] rec_pc,
    output logic [2:0]  rec_reg,
    output logic [15:0] rec_value,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_mdata,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count,
    output logic [15:0] drop_count,
    output logic        overflow,
    output logic        halted
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        K_REG  = 3'd0,
        K_LD   = 3'd1,
        K_STU  = 3'd2,
        K_ST   = 3'd3,
        K_HALT = 3'd4,
        K_NOP  = 3'd5
    } kind_e;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [2:0]  rreg;
        logic [15:0] value;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic        halted_q, halted_d;

    rec_t        entry_q [DEPTH];
    rec_t        cap_rec;
    rec_t        head_rec;
    kind_e       cap_kind;

    logic        fifo_empty;
    logic        fifo_full;
    logic        capture;
    logic        do_pop;
    logic        do_push;
    logic        do_drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A capture happens on every running edge; a halted core produces nothing.
    assign capture = !rst && !halted_q;
    assign do_pop  = !rst && !fifo_empty && rec_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign do_push = capture && (!fifo_full || do_pop);
    assign do_drop = capture && fifo_full && !do_pop;

    // Classify the retiring instruction by priority and zero unused fields so
    // undriven memory/register buses never leak into the record.
    always_comb begin
        cap_kind = K_NOP;
        cap_rec  = '0;
        if (reg_write && mem_write) begin
            cap_kind = K_STU;
        end else if (reg_write && mem_read) begin
            cap_kind = K_LD;
        end else if (reg_write) begin
            cap_kind = K_REG;
        end else if (halt) begin
            cap_kind = K_HALT;
        end else if (mem_write) begin
            cap_kind = K_ST;
        end
        cap_rec.kind = cap_kind;
        cap_rec.inum = inst_count_q;
        cap_rec.pc   = pc;
        if (cap_kind == K_REG || cap_kind == K_LD || cap_kind == K_STU) begin
            cap_rec.rreg  = write_reg;
            cap_rec.value = write_data;
        end
        if (cap_kind == K_LD || cap_kind == K_STU || cap_kind == K_ST) begin
            cap_rec.addr = mem_addr;
        end
        if (cap_kind == K_STU || cap_kind == K_ST) begin
            cap_rec.mdata = mem_data;
        end
    end

    // Record storage: each slot loads the captured record when it is the
    // write target; the head is read combinationally for fall-through.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    entry_q[gi] <= cap_rec;
                end
            end
        end
    endgenerate

    assign head_rec = entry_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers, counters and sticky status flags.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inst_count_d  = inst_count_q;
        cycle_count_d = cycle_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        halted_d      = halted_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (capture) begin
            inst_count_d  = inst_count_q + 32'd1;
            cycle_count_d = cycle_count_q + 32'd1;
            if (cap_kind == K_HALT) begin
                halted_d = 1'b1;
            end
        end
        if (do_drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    // State register with synchronous reset that empties the FIFO and
    // clears every counter and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            halted_q      <= halted_d;
        end
    end

    // Head fields are forced to zero whenever no record is present.
    always_comb begin
        rec_valid = !fifo_empty;
        rec_kind  = '0;
        rec_inum  = '0;
        rec_pc    = '0;
        rec_reg   = '0;
        rec_value = '0;
        rec_addr  = '0;
        rec_mdata = '0;
        if (!fifo_empty) begin
            rec_kind  = head_rec.kind;
            rec_inum  = head_rec.inum;
            rec_pc    = head_rec.pc;
            rec_reg   = head_rec.rreg;
            rec_value = head_rec.value;
            rec_addr  = head_rec.addr;
            rec_mdata = head_rec.mdata;
        end
    end

    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Bench for retire_trace_buf: table of classification vectors, directed
// multi-cycle sequences and a randomized run, all checked every cycle
// against a queue-based reference model.
module tb_retire_trace_buf;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        halt;
    logic        rec_ready;
    logic        rec_valid;
    logic [2:0]  rec_kind;
    logic [31:0] rec_inum;
    logic [15:0] rec_pc;
    logic [2:0]  rec_reg;
    logic [15:0] rec_value;
    logic [15:0] rec_addr;
    logic [15:0] rec_mdata;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic [15:0] drop_count;
    logic        overflow;
    logic        halted;

    retire_trace_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .halt(halt), .rec_ready(rec_ready), .rec_valid(rec_valid),
        .rec_kind(rec_kind), .rec_inum(rec_inum), .rec_pc(rec_pc),
        .rec_reg(rec_reg), .rec_value(rec_value), .rec_addr(rec_addr),
        .rec_mdata(rec_mdata), .inst_count(inst_count),
        .cycle_count(cycle_count), .drop_count(drop_count),
        .overflow(overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [2:0]  rreg;
        logic [15:0] value;
        logic [15:0] addr;
        logic [15:0] mdata;
    } mrec_t;

    mrec_t       mq[$];
    logic [31:0] m_inst;
    logic [31:0] m_cyc;
    logic [15:0] m_drop;
    logic        m_ovf;
    logic        m_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge, using the inputs currently driven.
    task automatic model_edge();
        mrec_t r;
        bit    pop_now;
        if (rst) begin
            mq.delete();
            m_inst = 0; m_cyc = 0; m_drop = 0; m_ovf = 0; m_halt = 0;
            return;
        end
        pop_now = (mq.size() > 0) && rec_ready;
        if (pop_now) mq.delete(0);
        if (!m_halt) begin
            if (reg_write && mem_write)     r.kind = 3'd2;
            else if (reg_write && mem_read) r.kind = 3'd1;
            else if (reg_write)             r.kind = 3'd0;
            else if (halt)                  r.kind = 3'd4;
            else if (mem_write)             r.kind = 3'd3;
            else                            r.kind = 3'd5;
            r.inum  = m_inst;
            r.pc    = pc;
            r.rreg  = (r.kind <= 3'd2) ? write_reg : 3'd0;
            r.value = (r.kind <= 3'd2) ? write_data : 16'd0;
            r.addr  = (r.kind >= 3'd1 && r.kind <= 3'd3) ? mem_addr : 16'd0;
            r.mdata = (r.kind == 3'd2 || r.kind == 3'd3) ? mem_data : 16'd0;
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            m_inst = m_inst + 32'd1;
            m_cyc  = m_cyc + 32'd1;
            if (r.kind == 3'd4) m_halt = 1'b1;
        end
    endtask

    task automatic compare_model();
        mrec_t h;
        chk("valid", {31'd0, rec_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) h = mq[0];
        else begin
            h.kind = 0; h.inum = 0; h.pc = 0; h.rreg = 0;
            h.value = 0; h.addr = 0; h.mdata = 0;
        end
        chk("kind", 32'(rec_kind), 32'(h.kind));
        chk("inum", rec_inum, h.inum);
        chk("pc", 32'(rec_pc), 32'(h.pc));
        chk("reg", 32'(rec_reg), 32'(h.rreg));
        chk("value", 32'(rec_value), 32'(h.value));
        chk("addr", 32'(rec_addr), 32'(h.addr));
        chk("mdata", 32'(rec_mdata), 32'(h.mdata));
        chk("inst_count", inst_count, m_inst);
        chk("cycle_count", cycle_count, m_cyc);
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic rw, input logic mr, input logic mw,
                          input logic h, input logic rdy);
        reg_write = rw; mem_read = mr; mem_write = mw; halt = h; rec_ready = rdy;
        pc = 16'($urandom); write_reg = 3'($urandom); write_data = 16'($urandom);
        mem_addr = 16'($urandom); mem_data = 16'($urandom);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rw, mr, mw, h;
        logic [2:0] kind;
        logic       ereg, eaddr, emd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tbl[0] = '{1, 0, 0, 0, 3'd0, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 3'd1, 1, 1, 0};
        tbl[2] = '{1, 0, 1, 0, 3'd2, 1, 1, 1};
        tbl[3] = '{1, 1, 1, 0, 3'd2, 1, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 3'd4, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 0, 3'd3, 0, 1, 1};
        tbl[6] = '{0, 1, 0, 0, 3'd5, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 3'd5, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 1, 3'd4, 0, 0, 0};
        tbl[9] = '{1, 1, 0, 1, 3'd1, 1, 1, 0};

        // Reset state
        do_reset();
        chk("rst_valid", 32'(rec_valid), 0);
        chk("rst_inst", inst_count, 0);
        chk("rst_halted", 32'(halted), 0);

        // Classification table: one capture into an empty FIFO per vector
        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_in(tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].h, 0);
            tick();
            chk($sformatf("tbl%0d_kind", i), 32'(rec_kind), 32'(tbl[i].kind));
            chk($sformatf("tbl%0d_inum", i), rec_inum, 0);
            chk($sformatf("tbl%0d_pc", i), 32'(rec_pc), 32'(pc));
            chk($sformatf("tbl%0d_value", i), 32'(rec_value),
                tbl[i].ereg ? 32'(write_data) : 32'd0);
            chk($sformatf("tbl%0d_reg", i), 32'(rec_reg),
                tbl[i].ereg ? 32'(write_reg) : 32'd0);
            chk($sformatf("tbl%0d_addr", i), 32'(rec_addr),
                tbl[i].eaddr ? 32'(mem_addr) : 32'd0);
            chk($sformatf("tbl%0d_mdata", i), 32'(rec_mdata),
                tbl[i].emd ? 32'(mem_data) : 32'd0);
        end

        // Basic capture
        do_reset();
        set_in(1, 0, 0, 0, 0);
        write_reg = 3'd3; write_data = 16'h00AB; pc = 16'h0002;
        tick();
        chk("basic_valid", 32'(rec_valid), 1);
        chk("basic_kind", 32'(rec_kind), 0);
        chk("basic_inum", rec_inum, 0);
        chk("basic_reg", 32'(rec_reg), 3);
        chk("basic_value", 32'(rec_value), 32'h00AB);
        chk("basic_pc", 32'(rec_pc), 32'h0002);

        // Classification sequence STU, LD, ST, NOP, HALT with rec_ready=1
        do_reset();
        set_in(1, 0, 1, 0, 1); tick();
        chk("seq_k0", 32'(rec_kind), 2); chk("seq_i0", rec_inum, 0);
        set_in(1, 1, 0, 0, 1); tick();
        chk("seq_k1", 32'(rec_kind), 1); chk("seq_i1", rec_inum, 1);
        set_in(0, 0, 1, 0, 1); tick();
        chk("seq_k2", 32'(rec_kind), 3); chk("seq_i2", rec_inum, 2);
        set_in(0, 0, 0, 0, 1); tick();
        chk("seq_k3", 32'(rec_kind), 5); chk("seq_i3", rec_inum, 3);
        set_in(0, 0, 0, 1, 1); tick();
        chk("seq_k4", 32'(rec_kind), 4); chk("seq_i4", rec_inum, 4);
        chk("seq_halted", 32'(halted), 1);
        chk("seq_inst", inst_count, 5);
        set_in(1, 0, 0, 0, 1); tick(); tick();
        chk("seq_cyc_frozen", cycle_count, 5);
        chk("seq_drained", 32'(rec_valid), 0);

        // Overflow, then full-FIFO pop-and-push while draining
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 0, 0, 0); tick();
        end
        chk("ovf_drop", 32'(drop_count), 2);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_inst", inst_count, 10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_head%0d", i), rec_inum, 32'(i));
            set_in(1, 0, 0, 0, 1); tick();
            chk($sformatf("pp_drop%0d", i), 32'(drop_count), 2);
        end
        chk("pp_head_after", rec_inum, 10);

        // Mid-operation reset with 5 queued records and halted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 1, 0); tick();
        chk("mrst_halted_pre", 32'(halted), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_valid", 32'(rec_valid), 0);
        chk("mrst_inst", inst_count, 0);
        chk("mrst_cyc", cycle_count, 0);
        chk("mrst_halted", 32'(halted), 0);
        set_in(1, 0, 0, 0, 0); tick();
        chk("mrst_inum", rec_inum, 0);

        // Drain after halt: 3 records then HALT, then consume everything
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 1, 0); tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_inum%0d", i), rec_inum, 32'(i));
            chk($sformatf("drain_kind%0d", i), 32'(rec_kind), (i == 3) ? 32'd4 : 32'd0);
            set_in(1, 0, 0, 0, 1); tick();
        end
        chk("drain_empty", 32'(rec_valid), 0);
        tick();
        chk("drain_inst", inst_count, 4);

        // Randomized traffic with varying consumer back-pressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pr;
            pr = ((c / 200) % 3 == 0) ? 90 : (((c / 200) % 3 == 1) ? 50 : 10);
            set_in(1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 40) == 0, $urandom_range(0, 99) < pr);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
